eth_fcs_ctrl: RTL and testbench

Frame-level sequencer for the byte-wide `crc_engine` on the receive path, between the MAC byte stream and the UDP header parser. It drives the engine's `init`, `en` and `byte_in` signals and checks the residue at end of frame. It strips the 4-byte FCS from the forwarded stream and reports per-frame status: CRC pass/fail, runt, giant and length. It also keeps good/bad frame counters.

---
 rtl/eth_fcs_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_eth_fcs_ctrl.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_fcs_ctrl.sv
// Receive-path FCS sequencer: drives a byte-wide CRC-32 engine, holds back the
// trailing 4 FCS bytes, and reports per-frame status plus good/bad counters.

// Reflected CRC-32 (poly 0xEDB88320), register preset to all ones, no output
// inversion, so a frame ending in a correct FCS leaves the 0xDEBB20E3 residue.
module crc_engine (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        init,
   input  logic        en,
   input  logic [7:0]  byte_in,
   output logic [31:0] crc
);
   logic [31:0] crc_q;
   logic [31:0] crc_d;

   // Reload on init, otherwise fold one byte in LSB first when enabled.
   always_comb begin
      crc_d = crc_q;
      if (init) begin
         crc_d = 32'hFFFF_FFFF;
      end else if (en) begin
         crc_d = crc_q ^ {24'h0, byte_in};
         for (int i = 0; i < 8; i++) begin
            crc_d = crc_d[0] ? ((crc_d >> 1) ^ 32'hEDB8_8320) : (crc_d >> 1);
         end
      end
   end

   // Running remainder register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) crc_q <= 32'hFFFF_FFFF;
      else        crc_q <= crc_d;
   end

   assign crc = crc_q;
endmodule

module eth_fcs_ctrl #(
   parameter int unsigned MIN_LEN     = 64,
   parameter int unsigned MAX_LEN     = 1518,
   parameter logic [31:0] CHECK_VALUE = 32'hDEBB_20E3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        s_valid,
   input  logic [7:0]  s_data,
   input  logic        s_last,
   output logic        s_ready,
   output logic        m_valid,
   output logic [7:0]  m_data,
   output logic        m_last,
   input  logic        m_ready,
   output logic        stat_valid,
   output logic        stat_crc_ok,
   output logic        stat_runt,
   output logic        stat_giant,
   output logic [15:0] stat_len,
   output logic [31:0] cnt_good,
   output logic [31:0] cnt_bad
);
   typedef enum logic {RX, CHECK} state_t;

   state_t      state_q, state_d;
   logic [7:0]  buf_q [4];
   logic [7:0]  buf_d [4];
   logic [2:0]  buf_cnt_q, buf_cnt_d;
   logic [15:0] len_q, len_d;
   logic        stat_valid_q, stat_valid_d;
   logic        stat_crc_ok_q, stat_crc_ok_d;
   logic        stat_runt_q, stat_runt_d;
   logic        stat_giant_q, stat_giant_d;
   logic [15:0] stat_len_q, stat_len_d;
   logic [31:0] cnt_good_q, cnt_good_d;
   logic [31:0] cnt_bad_q, cnt_bad_d;

   logic        rst_n;
   logic        buf_full;
   logic        accept;
   logic        crc_init;
   logic [31:0] crc;
   logic        frame_ok;

   assign rst_n    = ~rst;
   assign buf_full = (buf_cnt_q == 3'd4);
   assign s_ready  = (state_q == RX) & (~buf_full | m_ready);
   assign accept   = s_valid & s_ready;
   assign m_valid  = (state_q == RX) & s_valid & buf_full;
   assign m_data   = buf_q[0];
   assign m_last   = m_valid & s_last;
   assign crc_init = (state_q == CHECK);

   crc_engine u_crc (
      .clk     (clk),
      .rst_n   (rst_n),
      .init    (crc_init),
      .en      (accept),
      .byte_in (s_data),
      .crc     (crc)
   );

   assign stat_valid  = stat_valid_q;
   assign stat_crc_ok = stat_crc_ok_q;
   assign stat_runt   = stat_runt_q;
   assign stat_giant  = stat_giant_q;
   assign stat_len    = stat_len_q;
   assign cnt_good    = cnt_good_q;
   assign cnt_bad     = cnt_bad_q;

   // Next-state: buffer/length tracking in RX, one-cycle verdict in CHECK.
   always_comb begin
      state_d       = state_q;
      buf_d         = buf_q;
      buf_cnt_d     = buf_cnt_q;
      len_d         = len_q;
      stat_valid_d  = 1'b0;
      stat_crc_ok_d = stat_crc_ok_q;
      stat_runt_d   = stat_runt_q;
      stat_giant_d  = stat_giant_q;
      stat_len_d    = stat_len_q;
      cnt_good_d    = cnt_good_q;
      cnt_bad_d     = cnt_bad_q;
      frame_ok      = 1'b0;
      case (state_q)
         RX: begin
            if (accept) begin
               if (buf_full) begin
                  for (int i = 0; i < 3; i++) buf_d[i] = buf_q[i+1];
                  buf_d[3] = s_data;
               end else begin
                  buf_d[buf_cnt_q[1:0]] = s_data;
                  buf_cnt_d = buf_cnt_q + 3'd1;
               end
               len_d = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
               if (s_last) state_d = CHECK;
            end
         end
         CHECK: begin
            stat_valid_d  = 1'b1;
            stat_crc_ok_d = (crc == CHECK_VALUE);
            stat_runt_d   = (32'(len_q) < MIN_LEN);
            stat_giant_d  = (32'(len_q) > MAX_LEN);
            stat_len_d    = len_q;
            frame_ok      = stat_crc_ok_d & ~stat_runt_d & ~stat_giant_d;
            if (frame_ok) cnt_good_d = cnt_good_q + 32'd1;
            else          cnt_bad_d  = cnt_bad_q + 32'd1;
            buf_cnt_d     = 3'd0;
            len_d         = 16'd0;
            state_d       = RX;
         end
         default: state_d = RX;
      endcase
   end

   // State, buffer, length and status registers; reset drops any partial frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= RX;
         for (int i = 0; i < 4; i++) buf_q[i] <= 8'h00;
         buf_cnt_q     <= 3'd0;
         len_q         <= 16'd0;
         stat_valid_q  <= 1'b0;
         stat_crc_ok_q <= 1'b0;
         stat_runt_q   <= 1'b0;
         stat_giant_q  <= 1'b0;
         stat_len_q    <= 16'd0;
         cnt_good_q    <= 32'd0;
         cnt_bad_q     <= 32'd0;
      end else begin
         state_q       <= state_d;
         buf_q         <= buf_d;
         buf_cnt_q     <= buf_cnt_d;
         len_q         <= len_d;
         stat_valid_q  <= stat_valid_d;
         stat_crc_ok_q <= stat_crc_ok_d;
         stat_runt_q   <= stat_runt_d;
         stat_giant_q  <= stat_giant_d;
         stat_len_q    <= stat_len_d;
         cnt_good_q    <= cnt_good_d;
         cnt_bad_q     <= cnt_bad_d;
      end
   end
endmodule

// File: tb/tb_eth_fcs_ctrl.sv
// Bench for eth_fcs_ctrl: two instances (MIN_LEN=1 and defaults) share one
// stimulus stream; frames are built with a generated FCS and compared against
// expected payload, status and counters derived from frame lengths.
module tb_eth_fcs_ctrl;
   typedef struct {
      logic [7:0] data;
      logic       last;
   } beat_t;

   typedef struct {
      logic        crc_ok;
      logic        runt;
      logic        giant;
      logic [15:0] len;
      logic [31:0] good;
      logic [31:0] bad;
      int          cyc;
   } stat_t;

   logic        clk;
   logic        rst;
   logic        s_valid;
   logic [7:0]  s_data;
   logic        s_last;
   logic        m_ready;

   logic        s_ready_a, m_valid_a, m_last_a, stat_valid_a, stat_crc_ok_a, stat_runt_a, stat_giant_a;
   logic [7:0]  m_data_a;
   logic [15:0] stat_len_a;
   logic [31:0] cnt_good_a, cnt_bad_a;
   logic        s_ready_b, m_valid_b, m_last_b, stat_valid_b, stat_crc_ok_b, stat_runt_b, stat_giant_b;
   logic [7:0]  m_data_b;
   logic [15:0] stat_len_b;
   logic [31:0] cnt_good_b, cnt_bad_b;

   int          cyc = 0;
   int          total;
   int          passed;
   int          exp_good_a, exp_bad_a, exp_good_b, exp_bad_b;

   beat_t       out_a[$];
   beat_t       out_b[$];
   beat_t       exp_pay[$];
   stat_t       st_a[$];
   stat_t       st_b[$];
   logic [7:0]  stim_data[$];
   logic        stim_last[$];
   logic [7:0]  frame_buf[$];
   bit          exp_ok[$];
   int          exp_len[$];
   int          frame_end[$];
   int          acc_cyc[$];

   eth_fcs_ctrl #(.MIN_LEN(1)) dut_a (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready_a),
      .m_valid(m_valid_a), .m_data(m_data_a), .m_last(m_last_a), .m_ready(m_ready),
      .stat_valid(stat_valid_a), .stat_crc_ok(stat_crc_ok_a), .stat_runt(stat_runt_a),
      .stat_giant(stat_giant_a), .stat_len(stat_len_a), .cnt_good(cnt_good_a), .cnt_bad(cnt_bad_a)
   );

   eth_fcs_ctrl dut_b (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready_b),
      .m_valid(m_valid_b), .m_data(m_data_b), .m_last(m_last_b), .m_ready(m_ready),
      .stat_valid(stat_valid_b), .stat_crc_ok(stat_crc_ok_b), .stat_runt(stat_runt_b),
      .stat_giant(stat_giant_b), .stat_len(stat_len_b), .cnt_good(cnt_good_b), .cnt_bad(cnt_bad_b)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle index used to time acceptances and status pulses.
   always @(posedge clk) cyc <= cyc + 1;

   // Record every forwarded byte and status pulse of both instances.
   always @(negedge clk) begin
      beat_t mb;
      stat_t ms;
      if (!rst) begin
         if (m_valid_a && m_ready) begin
            mb.data = m_data_a; mb.last = m_last_a; out_a.push_back(mb);
         end
         if (m_valid_b && m_ready) begin
            mb.data = m_data_b; mb.last = m_last_b; out_b.push_back(mb);
         end
         if (stat_valid_a) begin
            ms.crc_ok = stat_crc_ok_a; ms.runt = stat_runt_a; ms.giant = stat_giant_a;
            ms.len = stat_len_a; ms.good = cnt_good_a; ms.bad = cnt_bad_a; ms.cyc = cyc;
            st_a.push_back(ms);
         end
         if (stat_valid_b) begin
            ms.crc_ok = stat_crc_ok_b; ms.runt = stat_runt_b; ms.giant = stat_giant_b;
            ms.len = stat_len_b; ms.good = cnt_good_b; ms.bad = cnt_bad_b; ms.cyc = cyc;
            st_b.push_back(ms);
         end
      end
   end

   task automatic clear_stim();
      stim_data.delete(); stim_last.delete(); exp_pay.delete(); exp_ok.delete();
      exp_len.delete(); frame_end.delete(); acc_cyc.delete();
      out_a.delete(); out_b.delete(); st_a.delete(); st_b.delete();
   endtask

   // Append frame_buf to the stream and derive its expected payload.
   task automatic push_frame(input bit ok);
      int    n;
      beat_t b;
      n = frame_buf.size();
      for (int i = 0; i < n; i++) begin
         stim_data.push_back(frame_buf[i]);
         stim_last.push_back(i == n - 1);
      end
      for (int i = 0; i < n - 4; i++) begin
         b.data = frame_buf[i]; b.last = (i == n - 5);
         exp_pay.push_back(b);
      end
      exp_len.push_back(n);
      exp_ok.push_back(ok);
      frame_end.push_back(stim_data.size() - 1);
      frame_buf.delete();
   endtask

   // Random payload plus standard Ethernet FCS (CRC-32, inverted, LSB byte first).
   task automatic make_random(input int plen, input bit corrupt);
      logic [31:0] c;
      logic [7:0]  b;
      int          pos;
      frame_buf.delete();
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < plen; i++) begin
         b = 8'($urandom);
         frame_buf.push_back(b);
         c = c ^ {24'h0, b};
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      c = ~c;
      for (int k = 0; k < 4; k++) frame_buf.push_back(c[8*k +: 8]);
      if (corrupt) begin
         pos = int'($urandom_range(0, plen + 3));
         frame_buf[pos] = frame_buf[pos] ^ 8'($urandom_range(1, 255));
      end
      push_frame(!corrupt);
   endtask

   // Drive the whole stream with s_valid held high; m_ready per mode (0 on, 1 toggle, 2 random).
   task automatic drive_all(input int mode);
      bit done;
      int guard;
      if (mode == 0) m_ready = 1'b1;
      for (int i = 0; i < stim_data.size(); i++) begin
         s_valid = 1'b1; s_data = stim_data[i]; s_last = stim_last[i];
         done = 1'b0; guard = 0;
         while (!done) begin
            @(negedge clk);
            if (s_ready_a) begin
               acc_cyc.push_back(cyc);
               done = 1'b1;
            end
            @(posedge clk); #1;
            if (mode == 1)      m_ready = ~m_ready;
            else if (mode == 2) m_ready = 1'($urandom_range(0, 1));
            else                m_ready = 1'b1;
            guard++;
            if (!done && guard > 64) begin
               total++;
               $display("[TB] FAIL accept_timeout: byte %0d still not accepted after %0d cycles, required acceptance", i, guard);
               done = 1'b1;
            end
         end
      end
      s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic load_vector(input logic [7:0] last_byte);
      logic [7:0] v [13];
      v = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};
      v[12] = last_byte;
      frame_buf.delete();
      for (int i = 0; i < 13; i++) frame_buf.push_back(v[i]);
   endtask

   task automatic test_reset();
      rst = 1'b1; s_valid = 1'b1; s_last = 1'b1; s_data = 8'hA5; m_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if (s_ready_a !== 1'b1) $display("[TB] FAIL rst_s_ready: got %b want 1", s_ready_a); else passed++;
      total++; if (m_valid_a !== 1'b0) $display("[TB] FAIL rst_m_valid: got %b want 0", m_valid_a); else passed++;
      total++; if (m_data_a !== 8'h00) $display("[TB] FAIL rst_m_data: got %h want 00", m_data_a); else passed++;
      total++; if (m_last_a !== 1'b0) $display("[TB] FAIL rst_m_last: got %b want 0", m_last_a); else passed++;
      total++; if (stat_valid_a !== 1'b0) $display("[TB] FAIL rst_stat_valid: got %b want 0", stat_valid_a); else passed++;
      total++; if ({stat_crc_ok_a, stat_runt_a, stat_giant_a} !== 3'b000)
         $display("[TB] FAIL rst_stat_flags: got %b want 000", {stat_crc_ok_a, stat_runt_a, stat_giant_a}); else passed++;
      total++; if (stat_len_a !== 16'd0) $display("[TB] FAIL rst_stat_len: got %0d want 0", stat_len_a); else passed++;
      total++; if (cnt_good_a !== 32'd0 || cnt_bad_a !== 32'd0)
         $display("[TB] FAIL rst_counters: got %0d/%0d want 0/0", cnt_good_a, cnt_bad_a); else passed++;
      total++; if ({s_ready_b, m_valid_b, m_data_b, m_last_b, stat_valid_b, stat_crc_ok_b, stat_runt_b, stat_giant_b,
                    stat_len_b, cnt_good_b, cnt_bad_b} !== {1'b1, 1'b0, 8'h00, 1'b0, 4'h0, 16'd0, 32'd0, 32'd0})
         $display("[TB] FAIL rst_outputs_b: got s_ready=%b m_valid=%b m_data=%h cnt=%0d/%0d want reset values",
                  s_ready_b, m_valid_b, m_data_b, cnt_good_b, cnt_bad_b); else passed++;
      s_valid = 1'b0; s_last = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_good_a = 0; exp_bad_a = 0; exp_good_b = 0; exp_bad_b = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_good_frame();
      clear_stim();
      load_vector(8'hCB);
      push_frame(1'b1);
      drive_all(0);
      exp_good_a++; exp_bad_b++;
      total++; if (out_a.size() != 9) $display("[TB] FAIL good_payload_count: got %0d want 9", out_a.size()); else passed++;
      for (int i = 0; i < 9 && i < out_a.size(); i++) begin
         total++;
         if (out_a[i].data !== 8'(8'h31 + i) || out_a[i].last !== (i == 8))
            $display("[TB] FAIL good_payload[%0d]: got %h/%b want %h/%b", i, out_a[i].data, out_a[i].last, 8'(8'h31 + i), (i == 8));
         else passed++;
      end
      total++; if (st_a.size() != 1 || st_b.size() != 1)
         $display("[TB] FAIL good_stat_pulses: got %0d/%0d want 1/1", st_a.size(), st_b.size()); else passed++;
      if (st_a.size() > 0 && st_b.size() > 0 && acc_cyc.size() == 13) begin
         total++; if (st_a[0].crc_ok !== 1'b1 || st_a[0].len !== 16'd13 || st_a[0].runt !== 1'b0 || st_a[0].giant !== 1'b0)
            $display("[TB] FAIL good_status_a: got ok=%b len=%0d runt=%b giant=%b want 1/13/0/0",
                     st_a[0].crc_ok, st_a[0].len, st_a[0].runt, st_a[0].giant); else passed++;
         total++; if (st_a[0].good !== 32'(exp_good_a) || st_a[0].bad !== 32'(exp_bad_a))
            $display("[TB] FAIL good_counters_a: got %0d/%0d want %0d/%0d", st_a[0].good, st_a[0].bad, exp_good_a, exp_bad_a); else passed++;
         total++; if (st_b[0].runt !== 1'b1 || st_b[0].crc_ok !== 1'b1 || st_b[0].bad !== 32'(exp_bad_b))
            $display("[TB] FAIL good_runt_b: got runt=%b ok=%b bad=%0d want 1/1/%0d", st_b[0].runt, st_b[0].crc_ok, st_b[0].bad, exp_bad_b); else passed++;
         total++; if (st_a[0].cyc != acc_cyc[12] + 2)
            $display("[TB] FAIL good_stat_timing: got cycle %0d want %0d", st_a[0].cyc, acc_cyc[12] + 2); else passed++;
      end
      total++; if (stat_valid_a !== 1'b0 || stat_len_a !== 16'd13)
         $display("[TB] FAIL good_stat_hold: got valid=%b len=%0d want 0/13", stat_valid_a, stat_len_a); else passed++;
   endtask

   task automatic test_crc_error();
      clear_stim();
      load_vector(8'hCA);
      push_frame(1'b0);
      drive_all(0);
      exp_bad_a++; exp_bad_b++;
      total++; if (out_a.size() != 9) $display("[TB] FAIL bad_payload_count: got %0d want 9", out_a.size()); else passed++;
      for (int i = 0; i < 9 && i < out_a.size(); i++) begin
         total++;
         if (out_a[i].data !== 8'(8'h31 + i) || out_a[i].last !== (i == 8))
            $display("[TB] FAIL bad_payload[%0d]: got %h/%b want %h/%b", i, out_a[i].data, out_a[i].last, 8'(8'h31 + i), (i == 8));
         else passed++;
      end
      total++; if (st_a.size() != 1) $display("[TB] FAIL bad_stat_pulses: got %0d want 1", st_a.size()); else passed++;
      if (st_a.size() > 0) begin
         total++; if (st_a[0].crc_ok !== 1'b0 || st_a[0].len !== 16'd13)
            $display("[TB] FAIL bad_status_a: got ok=%b len=%0d want 0/13", st_a[0].crc_ok, st_a[0].len); else passed++;
         total++; if (st_a[0].good !== 32'(exp_good_a) || st_a[0].bad !== 32'(exp_bad_a))
            $display("[TB] FAIL bad_counters_a: got %0d/%0d want %0d/%0d", st_a[0].good, st_a[0].bad, exp_good_a, exp_bad_a); else passed++;
      end
   endtask

   task automatic test_back_to_back();
      bit rt, gt;
      clear_stim();
      make_random(int'($urandom_range(16, 40)), 1'b0);
      make_random(int'($urandom_range(16, 40)), 1'b0);
      m_ready = 1'b0;
      drive_all(1);
      total++; if (acc_cyc.size() != stim_data.size() || acc_cyc[frame_end[0] + 1] - acc_cyc[frame_end[0]] != 2)
         $display("[TB] FAIL b2b_bubble: got gap %0d want 2", acc_cyc[frame_end[0] + 1] - acc_cyc[frame_end[0]]); else passed++;
      total++; if (out_a.size() != exp_pay.size() || out_b.size() != exp_pay.size())
         $display("[TB] FAIL b2b_payload_count: got %0d/%0d want %0d", out_a.size(), out_b.size(), exp_pay.size()); else passed++;
      for (int i = 0; i < exp_pay.size() && i < out_a.size() && i < out_b.size(); i++) begin
         total++;
         if (out_a[i].data !== exp_pay[i].data || out_a[i].last !== exp_pay[i].last || out_b[i].data !== exp_pay[i].data)
            $display("[TB] FAIL b2b_payload[%0d]: got %h/%b want %h/%b", i, out_a[i].data, out_a[i].last, exp_pay[i].data, exp_pay[i].last);
         else passed++;
      end
      total++; if (st_a.size() != 2) $display("[TB] FAIL b2b_stat_pulses: got %0d want 2", st_a.size()); else passed++;
      for (int k = 0; k < 2 && k < st_a.size(); k++) begin
         rt = (exp_len[k] < 1); gt = (exp_len[k] > 1518);
         if (exp_ok[k] && !rt && !gt) exp_good_a++; else exp_bad_a++;
         total++;
         if (st_a[k].crc_ok !== 1'b1 || st_a[k].len !== 16'(exp_len[k]) || st_a[k].good !== 32'(exp_good_a) || st_a[k].bad !== 32'(exp_bad_a))
            $display("[TB] FAIL b2b_status[%0d]: got ok=%b len=%0d cnt=%0d/%0d want 1/%0d/%0d/%0d",
                     k, st_a[k].crc_ok, st_a[k].len, st_a[k].good, st_a[k].bad, exp_len[k], exp_good_a, exp_bad_a);
         else passed++;
         total++; if (acc_cyc.size() > frame_end[k] && st_a[k].cyc != acc_cyc[frame_end[k]] + 2)
            $display("[TB] FAIL b2b_stat_timing[%0d]: got %0d want %0d", k, st_a[k].cyc, acc_cyc[frame_end[k]] + 2); else passed++;
      end
      for (int k = 0; k < exp_len.size(); k++) begin
         if (exp_ok[k] && exp_len[k] >= 64 && exp_len[k] <= 1518) exp_good_b++; else exp_bad_b++;
      end
   endtask

   // Frame lengths around both limits, including FCS-only frames; one instance per MIN_LEN.
   task automatic check_stream_lengths(input string tag);
      bit rta, rtb, gt, goa, gob;
      total++; if (out_a.size() != exp_pay.size() || out_b.size() != exp_pay.size())
         $display("[TB] FAIL %s_payload_count: got %0d/%0d want %0d", tag, out_a.size(), out_b.size(), exp_pay.size()); else passed++;
      for (int i = 0; i < exp_pay.size() && i < out_a.size() && i < out_b.size(); i++) begin
         total++;
         if (out_a[i].data !== exp_pay[i].data || out_a[i].last !== exp_pay[i].last ||
             out_b[i].data !== exp_pay[i].data || out_b[i].last !== exp_pay[i].last)
            $display("[TB] FAIL %s_payload[%0d]: got %h/%b want %h/%b", tag, i, out_a[i].data, out_a[i].last, exp_pay[i].data, exp_pay[i].last);
         else passed++;
      end
      total++; if (st_a.size() != exp_len.size() || st_b.size() != exp_len.size())
         $display("[TB] FAIL %s_stat_pulses: got %0d/%0d want %0d", tag, st_a.size(), st_b.size(), exp_len.size()); else passed++;
      for (int k = 0; k < exp_len.size(); k++) begin
         rta = (exp_len[k] < 1); rtb = (exp_len[k] < 64); gt = (exp_len[k] > 1518);
         goa = exp_ok[k] && !rta && !gt; gob = exp_ok[k] && !rtb && !gt;
         if (goa) exp_good_a++; else exp_bad_a++;
         if (gob) exp_good_b++; else exp_bad_b++;
         if (k < st_a.size() && k < st_b.size()) begin
            total++;
            if (st_a[k].crc_ok !== exp_ok[k] || st_a[k].runt !== rta || st_a[k].giant !== gt || st_a[k].len !== 16'(exp_len[k]) ||
                st_a[k].good !== 32'(exp_good_a) || st_a[k].bad !== 32'(exp_bad_a))
               $display("[TB] FAIL %s_status_a[%0d]: got ok=%b runt=%b giant=%b len=%0d cnt=%0d/%0d want %b/%b/%b/%0d/%0d/%0d",
                        tag, k, st_a[k].crc_ok, st_a[k].runt, st_a[k].giant, st_a[k].len, st_a[k].good, st_a[k].bad,
                        exp_ok[k], rta, gt, exp_len[k], exp_good_a, exp_bad_a);
            else passed++;
            total++;
            if (st_b[k].crc_ok !== exp_ok[k] || st_b[k].runt !== rtb || st_b[k].giant !== gt || st_b[k].len !== 16'(exp_len[k]) ||
                st_b[k].good !== 32'(exp_good_b) || st_b[k].bad !== 32'(exp_bad_b))
               $display("[TB] FAIL %s_status_b[%0d]: got ok=%b runt=%b giant=%b len=%0d cnt=%0d/%0d want %b/%b/%b/%0d/%0d/%0d",
                        tag, k, st_b[k].crc_ok, st_b[k].runt, st_b[k].giant, st_b[k].len, st_b[k].good, st_b[k].bad,
                        exp_ok[k], rtb, gt, exp_len[k], exp_good_b, exp_bad_b);
            else passed++;
         end
      end
   endtask

   task automatic test_length_limits();
      clear_stim();
      make_random(56, 1'b0);    // 60 bytes: runt by default
      make_random(59, 1'b0);    // 63
      make_random(60, 1'b0);    // 64: minimum legal
      make_random(0, 1'b0);     // 4: FCS only, no payload
      make_random(1, 1'b1);     // 5: one payload byte, bad FCS
      make_random(1514, 1'b0);  // 1518: maximum legal
      make_random(1515, 1'b0);  // 1519: giant
      drive_all(0);
      check_stream_lengths("limits");
   endtask

   task automatic test_random_frames();
      clear_stim();
      for (int f = 0; f < 10; f++) make_random(int'($urandom_range(0, 90)), 1'($urandom_range(0, 1)));
      m_ready = 1'b1;
      drive_all(2);
      check_stream_lengths("random");
   endtask

   task automatic test_reset_midframe();
      clear_stim();
      for (int i = 0; i < 7; i++) begin
         stim_data.push_back(8'(8'h31 + i));
         stim_last.push_back(1'b0);
      end
      drive_all(0);
      rst = 1'b1;
      @(negedge clk);
      total++; if (s_ready_a !== 1'b1 || m_valid_a !== 1'b0 || m_data_a !== 8'h00 || m_last_a !== 1'b0)
         $display("[TB] FAIL midrst_stream: got s_ready=%b m_valid=%b m_data=%h m_last=%b want 1/0/00/0",
                  s_ready_a, m_valid_a, m_data_a, m_last_a); else passed++;
      total++; if (cnt_good_a !== 32'd0 || cnt_bad_a !== 32'd0 || cnt_good_b !== 32'd0 || cnt_bad_b !== 32'd0)
         $display("[TB] FAIL midrst_counters: got %0d/%0d %0d/%0d want 0", cnt_good_a, cnt_bad_a, cnt_good_b, cnt_bad_b); else passed++;
      total++; if ({stat_valid_a, stat_crc_ok_a, stat_runt_a, stat_giant_a} !== 4'h0 || stat_len_a !== 16'd0)
         $display("[TB] FAIL midrst_status: got flags=%b len=%0d want 0000/0",
                  {stat_valid_a, stat_crc_ok_a, stat_runt_a, stat_giant_a}, stat_len_a); else passed++;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_good_a = 0; exp_bad_a = 0; exp_good_b = 0; exp_bad_b = 0;
      @(posedge clk); #1;
      clear_stim();
      load_vector(8'hCB);
      push_frame(1'b1);
      drive_all(0);
      total++; if (st_a.size() != 1) $display("[TB] FAIL midrst_stat_pulses: got %0d want 1", st_a.size()); else passed++;
      if (st_a.size() > 0) begin
         total++; if (st_a[0].len !== 16'd13 || st_a[0].crc_ok !== 1'b1 || st_a[0].good !== 32'd1 || st_a[0].bad !== 32'd0)
            $display("[TB] FAIL midrst_next_frame: got len=%0d ok=%b cnt=%0d/%0d want 13/1/1/0",
                     st_a[0].len, st_a[0].crc_ok, st_a[0].good, st_a[0].bad); else passed++;
      end
      total++; if (out_a.size() != 9 || (out_a.size() == 9 && (out_a[0].data !== 8'h31 || out_a[8].data !== 8'h39 || out_a[8].last !== 1'b1)))
         $display("[TB] FAIL midrst_payload: got %0d bytes want 9 bytes 31..39", out_a.size()); else passed++;
   endtask

   // Test sequence.
   initial begin
      total = 0; passed = 0;
      exp_good_a = 0; exp_bad_a = 0; exp_good_b = 0; exp_bad_b = 0;
      rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; m_ready = 1'b1;
      test_reset();
      test_good_frame();
      test_crc_error();
      test_back_to_back();
      test_length_limits();
      test_random_frames();
      test_reset_midframe();
      $display("[TB] %0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
